// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: ALU opcodes, forward selects and the
// ID/EX and EX/MEM register layouts.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;

  typedef enum logic [1:0] {FWD_RF, FWD_EXM, FWD_WB} fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data, imm;
    logic            use_rs1, use_rs2, src_imm;
    logic [3:0]      alu_ctrl;
    logic            reg_write, mem_read, mem_write;
  } idex_t;

  typedef struct packed {
    logic            valid, reg_write, mem_read, mem_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] result, store_data;
    logic            zero;
  } exm_t;

  // A later stage can supply src only if it really writes a non-x0 register.
  function automatic logic fwd_hit(input logic v, input logic rw,
                                   input logic [4:0] rd, input logic [4:0] src);
    return v && rw && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

// File: rtl/rv32i_ex_stage_if.sv
// Decode / writeback / ALU / EX-MEM signal bundle around the EX stage.
interface rv32i_ex_stage_if;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_use_rs1, id_use_rs2, id_alu_src_imm;
  logic [3:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, mem_stall;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        stall_id;
  logic        exm_valid, exm_reg_write, exm_mem_read, exm_mem_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result, exm_store_data;
  logic        exm_zero;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_use_rs1, id_use_rs2, id_alu_src_imm, id_alu_ctrl,
           id_reg_write, id_mem_read, id_mem_write, flush, mem_stall,
           wb_valid, wb_reg_write, wb_rd, wb_data, alu_result, alu_zero,
    output alu_a, alu_b, alu_ctrl, stall_id, exm_valid, exm_reg_write,
           exm_mem_read, exm_mem_write, exm_rd, exm_result, exm_store_data, exm_zero
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_use_rs1, id_use_rs2, id_alu_src_imm, id_alu_ctrl,
           id_reg_write, id_mem_read, id_mem_write, flush, mem_stall,
           wb_valid, wb_reg_write, wb_rd, wb_data, alu_result, alu_zero,
    input  alu_a, alu_b, alu_ctrl, stall_id, exm_valid, exm_reg_write,
           exm_mem_read, exm_mem_write, exm_rd, exm_result, exm_store_data, exm_zero
  );
endinterface

// File: rtl/rv32i_fwd_unit.sv
// Per-operand bypass select: EX/MEM result, then MEM/WB data, then register file.
module rv32i_fwd_unit
  import rv32i_pkg::*;
(
  input  logic [4:0]  src,
  input  logic [31:0] rf_data,
  input  logic        exm_valid,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output fwd_sel_e    sel,
  output logic [31:0] data
);
  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (fwd_hit(exm_valid, exm_reg_write, exm_rd, src)) begin
      sel  = FWD_EXM;
      data = exm_result;
    end else if (fwd_hit(wb_valid, wb_reg_write, wb_rd, src)) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end
endmodule

// File: rtl/rv32i_ex_stage.sv
// RV32I execute stage: ID/EX and EX/MEM registers, operand bypass,
// load-use interlock, flush and memory back-pressure.
module rv32i_ex_stage
  import rv32i_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  rv32i_ex_stage_if.slave bus
);
  idex_t       idex, idex_d;
  exm_t        exm, exm_d;
  fwd_sel_e    sel_a, sel_b;
  logic [31:0] fwd_a, fwd_b;
  logic        load_use;
  logic        unused;

  assign load_use = idex.valid && idex.mem_read && (idex.rd != 5'd0) && bus.id_valid &&
                    ((bus.id_use_rs1 && bus.id_rs1 == idex.rd) ||
                     (bus.id_use_rs2 && bus.id_rs2 == idex.rd));

  // A flush already bubbles the consumer, so no need to hold decode for it.
  assign bus.stall_id = bus.mem_stall || (load_use && !bus.flush);

  always_comb begin
    idex_d           = '0;
    idex_d.valid     = bus.id_valid;
    idex_d.rs1       = bus.id_rs1;
    idex_d.rs2       = bus.id_rs2;
    idex_d.rd        = bus.id_rd;
    idex_d.rs1_data  = bus.id_rs1_data;
    idex_d.rs2_data  = bus.id_rs2_data;
    idex_d.imm       = bus.id_imm;
    idex_d.use_rs1   = bus.id_use_rs1;
    idex_d.use_rs2   = bus.id_use_rs2;
    idex_d.src_imm   = bus.id_alu_src_imm;
    idex_d.alu_ctrl  = bus.id_alu_ctrl;
    idex_d.reg_write = bus.id_reg_write;
    idex_d.mem_read  = bus.id_mem_read;
    idex_d.mem_write = bus.id_mem_write;
  end

  rv32i_fwd_unit u_fwd_rs1 (
    .src(idex.rs1), .rf_data(idex.rs1_data),
    .exm_valid(exm.valid), .exm_reg_write(exm.reg_write), .exm_rd(exm.rd), .exm_result(exm.result),
    .wb_valid(bus.wb_valid), .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
    .sel(sel_a), .data(fwd_a)
  );

  rv32i_fwd_unit u_fwd_rs2 (
    .src(idex.rs2), .rf_data(idex.rs2_data),
    .exm_valid(exm.valid), .exm_reg_write(exm.reg_write), .exm_rd(exm.rd), .exm_result(exm.result),
    .wb_valid(bus.wb_valid), .wb_reg_write(bus.wb_reg_write), .wb_rd(bus.wb_rd), .wb_data(bus.wb_data),
    .sel(sel_b), .data(fwd_b)
  );

  assign bus.alu_a    = idex.valid ? fwd_a : '0;
  assign bus.alu_b    = idex.valid ? (idex.src_imm ? idex.imm : fwd_b) : '0;
  assign bus.alu_ctrl = idex.valid ? idex.alu_ctrl : ALU_ADD;

  always_comb begin
    exm_d = '0;
    if (idex.valid) begin
      exm_d.valid      = 1'b1;
      exm_d.reg_write  = idex.reg_write;
      exm_d.mem_read   = idex.mem_read;
      exm_d.mem_write  = idex.mem_write;
      exm_d.rd         = idex.rd;
      exm_d.result     = bus.alu_result;
      exm_d.store_data = fwd_b;
      exm_d.zero       = bus.alu_zero;
    end
  end

  // Back-pressure freezes both registers; flush waits until it is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex <= '0;
      exm  <= '0;
    end else if (!bus.mem_stall) begin
      idex <= (bus.flush || load_use) ? '0 : idex_d;
      exm  <= exm_d;
    end
  end

  assign bus.exm_valid      = exm.valid;
  assign bus.exm_reg_write  = exm.reg_write;
  assign bus.exm_mem_read   = exm.mem_read;
  assign bus.exm_mem_write  = exm.mem_write;
  assign bus.exm_rd         = exm.rd;
  assign bus.exm_result     = exm.result;
  assign bus.exm_store_data = exm.store_data;
  assign bus.exm_zero       = exm.zero;

  // Use bits only matter for the hazard check on the incoming instruction.
  assign unused = ^{idex.use_rs1, idex.use_rs2, sel_a, sel_b};
endmodule

// File: tb/tb_rv32i_ex_stage.sv
// Self-checking bench for rv32i_ex_stage: directed pipeline scenarios plus a
// randomized run against an instruction-level reference model.
module tb_rv32i_ex_stage;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rv32i_ex_stage_if bus ();
  rv32i_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return {31'd0, a < b};
      4'd9: return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  // Combinational ALU leaf hanging off the stage
  assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  assign bus.alu_zero   = (bus.alu_result == 32'd0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic si, input logic [3:0] op, input logic rw, input logic mr);
    bus.id_valid = v;        bus.id_rd = rd;          bus.id_rs1 = rs1;       bus.id_rs2 = rs2;
    bus.id_rs1_data = d1;    bus.id_rs2_data = d2;    bus.id_imm = imm;
    bus.id_use_rs1 = v;      bus.id_use_rs2 = v && !si;
    bus.id_alu_src_imm = si; bus.id_alu_ctrl = op;    bus.id_reg_write = rw;
    bus.id_mem_read = mr;    bus.id_mem_write = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic set_wb(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_valid = v; bus.wb_reg_write = rw; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic test_reset();
    idle(); set_wb(1'b0, 1'b0, 5'd0, 32'd0); bus.flush = 1'b0; bus.mem_stall = 1'b0;
    #2;
    n_tests++; if (bus.exm_valid !== 1'b0 || bus.alu_a !== 32'd0 || bus.stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_initial: exm_valid=%b alu_a=%h stall_id=%b want 0", bus.exm_valid, bus.alu_a, bus.stall_id); end
    @(negedge clk); rst_n = 1'b1;
    step();
    drive(1'b1, 5'd4, 5'd1, 5'd2, 32'd3, 32'd3, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    step(); idle(); step();
    n_tests++; if (bus.exm_valid !== 1'b1 || bus.exm_result !== 32'd6) begin n_fail++; $display("FAIL reset_prefill: exm_valid=%b result=%h want 1/6", bus.exm_valid, bus.exm_result); end
    drive(1'b1, 5'd4, 5'd1, 5'd2, 32'd3, 32'd3, 32'd0, 1'b0, ALU_SUB, 1'b1, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.exm_valid !== 1'b0 || bus.exm_result !== 32'd0 || bus.exm_reg_write !== 1'b0 || bus.exm_rd !== 5'd0) begin n_fail++; $display("FAIL reset_exm: valid=%b result=%h rw=%b rd=%0d want all 0", bus.exm_valid, bus.exm_result, bus.exm_reg_write, bus.exm_rd); end
    n_tests++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_ctrl !== 4'd0 || bus.stall_id !== 1'b0) begin n_fail++; $display("FAIL reset_alu: a=%h b=%h ctrl=%h stall=%b want 0", bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.stall_id); end
    idle();
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    drive(1'b1, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    step(); idle();
    n_tests++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7 || bus.alu_ctrl !== ALU_ADD) begin n_fail++; $display("FAIL pass_alu: a=%h b=%h ctrl=%h want 5/7/0", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
    step();
    n_tests++; if (bus.exm_valid !== 1'b1 || bus.exm_result !== 32'd12 || bus.exm_rd !== 5'd3 || bus.exm_reg_write !== 1'b1) begin n_fail++; $display("FAIL pass_exm: valid=%b result=%h rd=%0d want 1/12/3", bus.exm_valid, bus.exm_result, bus.exm_rd); end
  endtask

  task automatic test_fwd_priority();
    set_wb(1'b1, 1'b1, 5'd1, 32'd99);
    drive(1'b1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd10, 1'b1, ALU_ADD, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd2, 5'd1, 5'd1, 32'd1, 32'd1, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    step(); idle();
    n_tests++; if (bus.alu_a !== 32'd10 || bus.alu_b !== 32'd10) begin n_fail++; $display("FAIL fwd_priority_ops: a=%0d b=%0d want 10/10", bus.alu_a, bus.alu_b); end
    step();
    n_tests++; if (bus.exm_result !== 32'd20 || bus.exm_rd !== 5'd2) begin n_fail++; $display("FAIL fwd_priority_result: result=%0d rd=%0d want 20/2", bus.exm_result, bus.exm_rd); end
    set_wb(1'b1, 1'b1, 5'd1, 32'd99);
    drive(1'b1, 5'd2, 5'd1, 5'd0, 32'd1, 32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    step(); idle();
    n_tests++; if (bus.alu_a !== 32'd99) begin n_fail++; $display("FAIL fwd_wb: a=%0d want 99", bus.alu_a); end
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_x0();
    set_wb(1'b1, 1'b1, 5'd0, 32'hBEEF);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hDEAD, 1'b1, ALU_ADD, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    step(); idle();
    n_tests++; if (bus.exm_result !== 32'hDEAD || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin n_fail++; $display("FAIL x0_fwd: exm=%h a=%h b=%h want DEAD/0/0", bus.exm_result, bus.alu_a, bus.alu_b); end
    step();
    n_tests++; if (bus.exm_result !== 32'd0 || bus.exm_rd !== 5'd7) begin n_fail++; $display("FAIL x0_result: result=%h rd=%0d want 0/7", bus.exm_result, bus.exm_rd); end
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 32'h100, 32'd0, 32'd0, 1'b1, ALU_ADD, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd6, 5'd5, 5'd5, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    #1;
    n_tests++; if (bus.stall_id !== 1'b1) begin n_fail++; $display("FAIL loaduse_stall: stall_id=%b want 1", bus.stall_id); end
    step();
    n_tests++; if (bus.stall_id !== 1'b0 || bus.alu_ctrl !== 4'd0 || bus.alu_a !== 32'd0) begin n_fail++; $display("FAIL loaduse_bubble: stall=%b ctrl=%h a=%h want 0", bus.stall_id, bus.alu_ctrl, bus.alu_a); end
    n_tests++; if (bus.exm_valid !== 1'b1 || bus.exm_mem_read !== 1'b1 || bus.exm_rd !== 5'd5) begin n_fail++; $display("FAIL loaduse_lw_exm: valid=%b mr=%b rd=%0d want 1/1/5", bus.exm_valid, bus.exm_mem_read, bus.exm_rd); end
    set_wb(1'b1, 1'b1, 5'd5, 32'h40);
    step(); idle();
    n_tests++; if (bus.exm_valid !== 1'b0 || bus.stall_id !== 1'b0) begin n_fail++; $display("FAIL loaduse_exm_bubble: valid=%b stall=%b want 0/0", bus.exm_valid, bus.stall_id); end
    n_tests++; if (bus.alu_a !== 32'h40 || bus.alu_b !== 32'h40) begin n_fail++; $display("FAIL loaduse_wb_fwd: a=%h b=%h want 40/40", bus.alu_a, bus.alu_b); end
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'd0);
    n_tests++; if (bus.exm_result !== 32'h80 || bus.exm_rd !== 5'd6) begin n_fail++; $display("FAIL loaduse_result: result=%h rd=%0d want 80/6", bus.exm_result, bus.exm_rd); end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 32'h100, 32'd0, 32'd0, 1'b1, ALU_ADD, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd6, 5'd5, 5'd5, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1;
    n_tests++; if (bus.stall_id !== 1'b0) begin n_fail++; $display("FAIL flush_hazard_stall: stall_id=%b want 0", bus.stall_id); end
    step(); bus.flush = 1'b0; idle();
    n_tests++; if (bus.alu_ctrl !== 4'd0 || bus.alu_a !== 32'd0 || bus.exm_mem_read !== 1'b1) begin n_fail++; $display("FAIL flush_bubble: ctrl=%h a=%h exm_mr=%b want 0/0/1", bus.alu_ctrl, bus.alu_a, bus.exm_mem_read); end
    step();
    n_tests++; if (bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL flush_exm: exm_valid=%b want 0", bus.exm_valid); end
    // flush raised while memory stalls must wait for the release
    drive(1'b1, 5'd8, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd11, 5'd1, 5'd2, 32'd50, 32'd50, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    bus.flush = 1'b1; bus.mem_stall = 1'b1;
    #1;
    n_tests++; if (bus.stall_id !== 1'b1) begin n_fail++; $display("FAIL flush_stall_sid: stall_id=%b want 1", bus.stall_id); end
    step();
    n_tests++; if (bus.alu_a !== 32'd1 || bus.alu_b !== 32'd2 || bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_hold: a=%0d b=%0d exm_valid=%b want 1/2/0", bus.alu_a, bus.alu_b, bus.exm_valid); end
    step();
    bus.mem_stall = 1'b0;
    step(); bus.flush = 1'b0; idle();
    n_tests++; if (bus.alu_ctrl !== 4'd0 || bus.alu_a !== 32'd0) begin n_fail++; $display("FAIL flush_after_stall: ctrl=%h a=%h want 0/0", bus.alu_ctrl, bus.alu_a); end
    n_tests++; if (bus.exm_valid !== 1'b1 || bus.exm_result !== 32'd3 || bus.exm_rd !== 5'd8) begin n_fail++; $display("FAIL flush_after_stall_exm: valid=%b result=%0d rd=%0d want 1/3/8", bus.exm_valid, bus.exm_result, bus.exm_rd); end
    step();
    n_tests++; if (bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL flush_killed: exm_valid=%b rd=%0d want 0", bus.exm_valid, bus.exm_rd); end
  endtask

  task automatic test_mem_stall();
    idle(); step();
    drive(1'b1, 5'd9, 5'd1, 5'd2, 32'd9, 32'd4, 32'd0, 1'b0, ALU_SUB, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd10, 5'd3, 5'd4, 32'd1, 32'd1, 32'd0, 1'b0, ALU_ADD, 1'b1, 1'b0);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (bus.alu_a !== 32'd9 || bus.alu_b !== 32'd4 || bus.alu_ctrl !== ALU_SUB) begin n_fail++; $display("FAIL mstall_alu[%0d]: a=%0d b=%0d ctrl=%h want 9/4/1", i, bus.alu_a, bus.alu_b, bus.alu_ctrl); end
      n_tests++; if (bus.exm_valid !== 1'b0 || bus.stall_id !== 1'b1) begin n_fail++; $display("FAIL mstall_exm[%0d]: exm_valid=%b stall=%b want 0/1", i, bus.exm_valid, bus.stall_id); end
    end
    bus.mem_stall = 1'b0;
    step(); idle();
    n_tests++; if (bus.exm_valid !== 1'b1 || bus.exm_result !== 32'd5 || bus.exm_rd !== 5'd9) begin n_fail++; $display("FAIL mstall_release: valid=%b result=%0d rd=%0d want 1/5/9", bus.exm_valid, bus.exm_result, bus.exm_rd); end
    n_tests++; if (bus.alu_a !== 32'd1 || bus.alu_ctrl !== ALU_ADD) begin n_fail++; $display("FAIL mstall_next: a=%0d ctrl=%h want 1/0", bus.alu_a, bus.alu_ctrl); end
    step();
    n_tests++; if (bus.exm_rd !== 5'd10 || bus.exm_result !== 32'd2) begin n_fail++; $display("FAIL mstall_order: rd=%0d result=%0d want 10/2", bus.exm_rd, bus.exm_result); end
    step();
    n_tests++; if (bus.exm_valid !== 1'b0) begin n_fail++; $display("FAIL mstall_dup: exm_valid=%b want 0", bus.exm_valid); end
  endtask

  // Reference model: the instruction in EX sees the result of the one just
  // ahead of it, else whatever writeback presents, else its register read.
  typedef struct packed {
    logic v; logic [4:0] rd, rs1, rs2; logic [31:0] d1, d2, imm; logic si; logic [3:0] op; logic rw;
  } ins_t;
  typedef struct packed { logic v; logic [4:0] rd; logic rw; logic [31:0] res, st; } done_t;

  ins_t  ex_q;
  done_t mem_q;

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (mem_q.v && mem_q.rw && mem_q.rd == r) return mem_q.res;
    if (bus.wb_valid && bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
    return rf;
  endfunction

  task automatic test_random();
    ins_t nx;
    logic stall, fl;
    logic [31:0] a, b, fb;
    idle(); step(); step();
    ex_q = '0; mem_q = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      nx.v = ($urandom_range(0, 3) != 0);
      nx.rd = 5'($urandom_range(0, 3)); nx.rs1 = 5'($urandom_range(0, 3)); nx.rs2 = 5'($urandom_range(0, 3));
      nx.d1 = $urandom; nx.d2 = $urandom; nx.imm = $urandom;
      nx.si = 1'($urandom_range(0, 1)); nx.op = 4'($urandom_range(0, 9)); nx.rw = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      drive(nx.v, nx.rd, nx.rs1, nx.rs2, nx.d1, nx.d2, nx.imm, nx.si, nx.op, nx.rw, 1'b0);
      bus.mem_stall = stall; bus.flush = fl;
      set_wb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      #1;
      a = ex_q.v ? operand(ex_q.rs1, ex_q.d1) : 32'd0;
      fb = operand(ex_q.rs2, ex_q.d2);
      b = ex_q.v ? (ex_q.si ? ex_q.imm : fb) : 32'd0;
      n_tests++; if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_ctrl !== (ex_q.v ? ex_q.op : 4'd0)) begin n_fail++; $display("FAIL rand_alu[%0d]: a=%h b=%h ctrl=%h want %h %h %h", cyc, bus.alu_a, bus.alu_b, bus.alu_ctrl, a, b, ex_q.v ? ex_q.op : 4'd0); end
      n_tests++; if (bus.stall_id !== stall || bus.exm_valid !== mem_q.v) begin n_fail++; $display("FAIL rand_ctl[%0d]: stall=%b exm_valid=%b want %b %b", cyc, bus.stall_id, bus.exm_valid, stall, mem_q.v); end
      if (mem_q.v) begin
        n_tests++; if (bus.exm_rd !== mem_q.rd || bus.exm_reg_write !== mem_q.rw || bus.exm_result !== mem_q.res || bus.exm_store_data !== mem_q.st || bus.exm_zero !== (mem_q.res == 32'd0)) begin n_fail++; $display("FAIL rand_exm[%0d]: rd=%0d rw=%b res=%h st=%h z=%b want %0d %b %h %h", cyc, bus.exm_rd, bus.exm_reg_write, bus.exm_result, bus.exm_store_data, bus.exm_zero, mem_q.rd, mem_q.rw, mem_q.res, mem_q.st); end
      end
      if (!stall) begin
        mem_q = ex_q.v ? {1'b1, ex_q.rd, ex_q.rw, alu_f(ex_q.op, a, b), fb} : '0;
        ex_q = fl ? '0 : nx;
      end
      step();
    end
    bus.mem_stall = 1'b0; bus.flush = 1'b0; idle(); set_wb(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_fwd_priority();
    test_x0();
    test_load_use();
    test_flush();
    test_mem_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rv32i_ex_stage.md
# rv32i_ex_stage

Drives the RV32I ALU from the pipeline side: holds the ID/EX pipeline register, selects forwarded operands, presents `alu_a`/`alu_b`/`alu_ctrl`, and captures `alu_result`/`alu_zero` into the EX/MEM register. It also detects load-use hazards, applies branch flushes and honours back-pressure from the memory stage. It sits between the decode stage and the memory stage of the 5-stage pipeline, and the ALU hangs off it as a combinational leaf.

## Interface
- No parameters; XLEN fixed at 32, register index 5 bits.
- `clk` in 1 — pipeline clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `id_valid` in 1 — decode stage presents an instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each — register indices.
- `id_rs1_data`, `id_rs2_data` in 32 each — register-file read data.
- `id_imm` in 32 — sign-extended immediate.
- `id_use_rs1`, `id_use_rs2` in 1 each — operand actually read.
- `id_alu_src_imm` in 1 — `alu_b` takes `imm` instead of rs2.
- `id_alu_ctrl` in 4 — ALU operation code.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1 each — control bits.
- `flush` in 1 — kill the instruction entering ID/EX.
- `mem_stall` in 1 — memory stage cannot accept.
- `wb_valid`, `wb_reg_write` in 1 each — writeback stage state.
- `wb_rd` in 5 — writeback destination.
- `wb_data` in 32 — writeback value.
- `alu_a`, `alu_b` out 32 each — ALU operands.
- `alu_ctrl` out 4 — ALU operation code.
- `alu_result` in 32, `alu_zero` in 1 — ALU outputs.
- `stall_id` out 1 — hold PC and IF/ID.
- `exm_valid`, `exm_reg_write`, `exm_mem_read`, `exm_mem_write` out 1 each — EX/MEM control.
- `exm_rd` out 5 — EX/MEM destination.
- `exm_result`, `exm_store_data` out 32 each — EX/MEM data.
- `exm_zero` out 1 — registered `alu_zero`.

## Operation
- **ID/EX register fields:** valid, rs1/rs2/rd, rs1/rs2 data, imm, use bits, src_imm, alu_ctrl, reg_write, mem_read, mem_write.
- **Update priority, highest first:**
  1. `mem_stall` holds both registers; `stall_id`=1.
  2. `flush` loads a bubble (valid=0, all control bits 0).
  3. Load-use hazard loads a bubble and asserts `stall_id`. The hazard is: ID/EX valid && ID/EX mem_read && ID/EX rd≠0 && `id_valid` && ((`id_use_rs1` && `id_rs1`==ID/EX rd) || (`id_use_rs2` && `id_rs2`==ID/EX rd)).
  4. Otherwise ID/EX loads the id_* inputs, with valid=`id_valid`.
- **`flush` with load-use hazard in the same cycle:** bubble, and `stall_id`=0.
- **`flush` with `mem_stall`:** flush is ignored. The source must hold `flush` until `mem_stall` deasserts.
- **EX/MEM register:** loads the ID/EX contents plus `alu_result`, `alu_zero` and the forwarded rs2 whenever `mem_stall`=0. A bubble propagates as `exm_valid`=0 with control bits 0.
- **Forwarding, per operand (combinational):**
  - EX/MEM source when `exm_valid` && `exm_reg_write` && `exm_rd`≠0 && `exm_rd`==src.
  - Else MEM/WB source when `wb_valid` && `wb_reg_write` && `wb_rd`≠0 && `wb_rd`==src.
  - Else register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- **Operand outputs:** `alu_a` = forwarded rs1. `alu_b` = src_imm ? imm : forwarded rs2. `exm_store_data` = forwarded rs2 regardless of src_imm.
- **Bubble in EX:** `alu_ctrl`=4'b0000 (ADD) and operands are 0.
- **Width rules:** no width arithmetic here. Shift amounts are truncated inside the ALU.

## Timing
- **Reset:** all ID/EX and EX/MEM fields clear to 0 immediately on `rst_n` low, giving `exm_*`=0, `alu_a`=`alu_b`=0, `alu_ctrl`=0 and `stall_id`=0. The first capture happens on the first rising edge after release.
- **Latency:** an instruction accepted at edge N drives the ALU during cycle N+1 and appears on `exm_*` after edge N+1.
- **`stall_id`:** combinational from ID/EX state and id_* inputs, valid in the same cycle. While it is high, decode must hold its inputs stable.
- **Load-use penalty:** exactly one bubble. The consumer then receives the load data through the MEM/WB path.
- **`mem_stall`:** any number of cycles. `alu_*` outputs stay stable, but forwarding values may change if `wb_*` changes.

## Structure
- **Shared package `rv32i_pkg`:**
  - ALU opcode constants: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU 1000, SLT 1001.
  - Forward-select enum: `FWD_RF`, `FWD_EXM`, `FWD_WB`.
- **Sub-module `rv32i_fwd_unit`:** combinational, instantiated twice (rs1, rs2). Returns the select and the forwarded value.

## Test plan
- **Reset and pass-through:** `rst_n` low mid-run → all `exm_*`=0 asynchronously. Then ADD x3 with rs1 data 5 and rs2 data 7, no hazards → `exm_result`=12 and `exm_rd`=3 two edges after acceptance.
- **EX/MEM over MEM/WB priority:** `addi x1,x0,10` followed by `add x2,x1,x1`, with `wb_rd`=1 and `wb_data`=99 present at the same time → `alu_a`=`alu_b`=10, `exm_result`=20.
- **x0 never forwarded:** producer writes x0 with result 0xDEAD; consumer reads x0 from a register file returning 0 → `alu_a`=0.
- **Load-use stall:** `lw x5` in EX while decode presents `add x6,x5,x5` → `stall_id`=1 for one cycle and one `exm_valid`=0 bubble. With `wb_data`=0x40 for x5, the add then yields `exm_result`=0x80.
- **Flush priority:** `flush` and a load-use hazard in the same cycle → bubble, `stall_id`=0. `flush` during `mem_stall` → ignored; the bubble is applied on the first cycle after `mem_stall` drops.
- **Memory back-pressure:** `mem_stall` held 3 cycles with a SUB (9−4) in EX → `alu_a`/`alu_b` steady. `exm_result`=5 appears only after the release edge, with no duplicated or lost instruction.
